// File: rtl/cv32e40p_x_resp_buffer_if.sv
// X-interface bundle between core, response buffer and coprocessor wrapper.
// The slave modport is the buffer's view; the master modport drives the buffer.
interface cv32e40p_x_resp_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  x_valid;
   logic                  x_ready;
   logic                  x_accept;
   logic                  x_writeback;
   logic                  x_q_valid;
   logic                  x_q_ready;
   logic                  x_k_accept;
   logic                  x_k_writeback;
   logic                  x_p_valid;
   logic                  x_p_ready;
   logic [4:0]            x_p_rd;
   logic [DATA_WIDTH-1:0] x_p_data;
   logic                  x_p_dualwb;
   logic                  x_p_type;
   logic                  x_p_error;
   logic                  x_rvalid;
   logic                  x_rready;
   logic [4:0]            x_rd;
   logic [DATA_WIDTH-1:0] x_data;
   logic                  x_dualwb;
   logic                  x_type;
   logic                  x_error;

   modport slave (
      input  x_valid, x_q_ready, x_k_accept, x_k_writeback,
      input  x_p_valid, x_p_rd, x_p_data, x_p_dualwb, x_p_type, x_p_error,
      input  x_rready,
      output x_ready, x_accept, x_writeback, x_q_valid, x_p_ready,
      output x_rvalid, x_rd, x_data, x_dualwb, x_type, x_error
   );

   modport master (
      output x_valid, x_q_ready, x_k_accept, x_k_writeback,
      output x_p_valid, x_p_rd, x_p_data, x_p_dualwb, x_p_type, x_p_error,
      output x_rready,
      input  x_ready, x_accept, x_writeback, x_q_valid, x_p_ready,
      input  x_rvalid, x_rd, x_data, x_dualwb, x_type, x_error
   );
endinterface

// File: rtl/cv32e40p_x_resp_buffer.sv
// Credit-managed X-interface response buffer: every accepted writeback offload owns a FIFO slot.
// Define CV32E40P_X_RESP_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module cv32e40p_x_resp_buffer #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   cv32e40p_x_resp_buffer_if.slave  x,
   output logic                     err_o
);
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int SUM_W   = $clog2(2 * DEPTH + 1);
   localparam int ENTRY_W = 5 + DATA_WIDTH + 3;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   pending;
   logic [SUM_W-1:0]   credit_sum;
   logic               credit_ok;
   logic               req_hs;
   logic               reserve;
   logic               push;
   logic               store;
   logic               fifo_empty;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic [ENTRY_W-1:0] out_entry;

   // Outstanding reservations plus queued entries must leave room for one more response.
   assign credit_sum = SUM_W'(pending) + SUM_W'(count);
   assign credit_ok  = credit_sum < SUM_W'(DEPTH);

   assign x.x_q_valid   = x.x_valid & credit_ok;
   assign x.x_ready     = x.x_q_ready & credit_ok;
   assign x.x_accept    = x.x_k_accept;
   assign x.x_writeback = x.x_k_writeback;
   assign req_hs        = x.x_valid & x.x_q_ready & credit_ok;
   assign reserve       = req_hs & x.x_k_accept & x.x_k_writeback;

   assign x.x_p_ready = count < CNT_W'(DEPTH);
   assign push        = x.x_p_valid & x.x_p_ready;
   assign push_entry  = {x.x_p_rd, x.x_p_data, x.x_p_dualwb, x.x_p_type, x.x_p_error};
   assign fifo_empty  = count == '0;
   assign head_entry  = mem[rd_ptr];

`ifdef CV32E40P_X_RESP_BYPASS_EN
   logic bypass;

   // A response landing in an empty FIFO is shown immediately and skips storage if taken.
   assign bypass     = fifo_empty & push;
   assign x.x_rvalid = ~fifo_empty | bypass;
   assign out_entry  = bypass ? push_entry : head_entry;
   assign store      = push & ~(bypass & x.x_rready);
`else
   assign x.x_rvalid = ~fifo_empty;
   assign out_entry  = head_entry;
   assign store      = push;
`endif

   assign fifo_pop = x.x_rvalid & x.x_rready & ~fifo_empty;
   assign {x.x_rd, x.x_data, x.x_dualwb, x.x_type, x.x_error} =
      x.x_rvalid ? out_entry : '0;

   always_ff @(posedge clk_i) begin
      if (store) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers wrap explicitly so non-power-of-two depths stay in range.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         pending <= '0;
         err_o   <= 1'b0;
      end else begin
         if (store) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         unique case ({store, fifo_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         unique case ({reserve, push})
            2'b10:   pending <= pending + CNT_W'(1);
            2'b01:   pending <= (pending != '0) ? pending - CNT_W'(1) : pending;
            default: pending <= pending;
         endcase
         if (push && pending == '0) begin
            err_o <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cv32e40p_x_resp_buffer.sv
// Scoreboard bench for cv32e40p_x_resp_buffer: directed offloads/responses, monitor checks replay order.
module tb_cv32e40p_x_resp_buffer;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        dw;
      logic        typ;
      logic        er;
   } resp_t;

`ifdef CV32E40P_X_RESP_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic  clk_i = 1'b0;
   logic  rst_ni;
   logic  err_o;
   int    total = 0;
   int    bad = 0;
   resp_t exp_q[$];

   cv32e40p_x_resp_buffer_if #(.DATA_WIDTH(32)) xif ();

   cv32e40p_x_resp_buffer #(.DEPTH(4), .DATA_WIDTH(32)) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .x     (xif.slave),
      .err_o (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      xif.x_valid       = 1'b0;
      xif.x_q_ready     = 1'b1;
      xif.x_k_accept    = 1'b0;
      xif.x_k_writeback = 1'b0;
      xif.x_p_valid     = 1'b0;
      xif.x_p_rd        = '0;
      xif.x_p_data      = '0;
      xif.x_p_dualwb    = 1'b0;
      xif.x_p_type      = 1'b0;
      xif.x_p_error     = 1'b0;
      xif.x_rready      = 1'b0;
   endtask

   task automatic doReset();
      idle();
      rst_ni = 1'b0;
      exp_q.delete();
      step();
      step();
      rst_ni = 1'b1;
   endtask

   // One offload request; the expected ready is checked before the edge that samples it.
   task automatic applyStimulus(input logic acc, input logic wb, input logic exp_ready);
      xif.x_valid       = 1'b1;
      xif.x_k_accept    = acc;
      xif.x_k_writeback = wb;
      #1;
      checkOutput("req_ready", 64'(xif.x_ready), 64'(exp_ready));
      checkOutput("req_q_valid", 64'(xif.x_q_valid), 64'(exp_ready));
      step();
      xif.x_valid       = 1'b0;
      xif.x_k_accept    = 1'b0;
      xif.x_k_writeback = 1'b0;
   endtask

   task automatic respond(input logic [4:0] rd, input logic [31:0] data,
                          input logic dw, input logic typ, input logic er);
      resp_t r;
      r.rd = rd; r.data = data; r.dw = dw; r.typ = typ; r.er = er;
      exp_q.push_back(r);
      xif.x_p_valid  = 1'b1;
      xif.x_p_rd     = rd;
      xif.x_p_data   = data;
      xif.x_p_dualwb = dw;
      xif.x_p_type   = typ;
      xif.x_p_error  = er;
      step();
      xif.x_p_valid  = 1'b0;
   endtask

   // Monitor: whenever a response is shown, it must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_ni && xif.x_rvalid) begin
            checkOutput("resp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               checkOutput("resp_payload",
                  64'({xif.x_rd, xif.x_data, xif.x_dualwb, xif.x_type, xif.x_error}),
                  64'({exp_q[0].rd, exp_q[0].data, exp_q[0].dw, exp_q[0].typ, exp_q[0].er}));
               if (xif.x_rready) begin
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      idle();
      rst_ni = 1'b0;
      #2;
      // Reset state and pass-through request path
      checkOutput("rst_rvalid", 64'(xif.x_rvalid), 64'd0);
      checkOutput("rst_err", 64'(err_o), 64'd0);
      checkOutput("rst_p_ready", 64'(xif.x_p_ready), 64'd1);
      checkOutput("rst_payload", 64'({xif.x_rd, xif.x_data, xif.x_dualwb, xif.x_type, xif.x_error}), 64'd0);
      xif.x_valid    = 1'b1;
      xif.x_k_accept = 1'b1;
      #1;
      checkOutput("rst_q_valid", 64'(xif.x_q_valid), 64'd1);
      checkOutput("rst_ready", 64'(xif.x_ready), 64'd1);
      checkOutput("rst_accept", 64'(xif.x_accept), 64'd1);
      checkOutput("rst_writeback", 64'(xif.x_writeback), 64'd0);
      doReset();

      // Single offload
      applyStimulus(1'b1, 1'b1, 1'b1);
      respond(5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
      checkOutput("single_rvalid", 64'(xif.x_rvalid), 64'd1);
      xif.x_rready = 1'b1;
      step();
      xif.x_rready = 1'b0;
      checkOutput("single_drained", 64'(xif.x_rvalid), 64'd0);
      checkOutput("single_err", 64'(err_o), 64'd0);

      // Credit exhaustion
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      respond(5'd1, 32'h11, 1'b1, 1'b0, 1'b0);
      checkOutput("credit_still_full", 64'(xif.x_ready), 64'd0);
      xif.x_rready = 1'b1;
      step();
      checkOutput("credit_released", 64'(xif.x_ready), 64'd1);
      respond(5'd2, 32'h22, 1'b0, 1'b0, 1'b1);
      respond(5'd3, 32'h33, 1'b1, 1'b1, 1'b0);
      respond(5'd4, 32'h44, 1'b0, 1'b0, 1'b0);
      step();
      xif.x_rready = 1'b0;
      checkOutput("credit_drained", 64'(xif.x_rvalid), 64'd0);
      checkOutput("credit_err", 64'(err_o), 64'd0);

      // Order and backpressure, with a refused push while full and popping
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 4; i++) respond(5'(i), 32'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("full_p_ready", 64'(xif.x_p_ready), 64'd0);
      checkOutput("full_rvalid", 64'(xif.x_rvalid), 64'd1);
      step();
      step();
      step();
      xif.x_rready  = 1'b1;
      xif.x_p_valid = 1'b1;
      xif.x_p_rd    = 5'd9;
      xif.x_p_data  = 32'h99;
      #1;
      checkOutput("full_pop_p_ready", 64'(xif.x_p_ready), 64'd0);
      step();
      xif.x_p_valid = 1'b0;
      step();
      step();
      step();
      xif.x_rready = 1'b0;
      checkOutput("order_drained", 64'(xif.x_rvalid), 64'd0);
      checkOutput("order_p_ready", 64'(xif.x_p_ready), 64'd1);
      checkOutput("order_err", 64'(err_o), 64'd0);

      // Non-writeback and rejected offloads reserve nothing
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      doReset();

      // Unsolicited response
      respond(5'd7, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
      checkOutput("unsol_err", 64'(err_o), 64'd1);
      checkOutput("unsol_rvalid", 64'(xif.x_rvalid), 64'd1);
      xif.x_rready = 1'b1;
      step();
      xif.x_rready = 1'b0;
      step();
      step();
      checkOutput("unsol_err_sticky", 64'(err_o), 64'd1);
      checkOutput("unsol_drained", 64'(xif.x_rvalid), 64'd0);

      // Reset mid-stream with count=3, pending=1
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      respond(5'd10, 32'hA0, 1'b0, 1'b0, 1'b0);
      respond(5'd11, 32'hA1, 1'b0, 1'b0, 1'b0);
      respond(5'd12, 32'hA2, 1'b0, 1'b0, 1'b0);
      checkOutput("mid_rvalid", 64'(xif.x_rvalid), 64'd1);
      rst_ni = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("mid_rst_rvalid", 64'(xif.x_rvalid), 64'd0);
      checkOutput("mid_rst_err", 64'(err_o), 64'd0);
      checkOutput("mid_rst_p_ready", 64'(xif.x_p_ready), 64'd1);
      step();
      rst_ni = 1'b1;
      begin
         resp_t r;
         r.rd = 5'd3; r.data = 32'h5A5A5A5A; r.dw = 1'b1; r.typ = 1'b0; r.er = 1'b1;
         exp_q.push_back(r);
      end
      xif.x_p_valid  = 1'b1;
      xif.x_p_rd     = 5'd3;
      xif.x_p_data   = 32'h5A5A5A5A;
      xif.x_p_dualwb = 1'b1;
      xif.x_p_type   = 1'b0;
      xif.x_p_error  = 1'b1;
      #1;
      checkOutput("empty_push_rvalid", 64'(xif.x_rvalid), 64'(BYP));
`ifdef CV32E40P_X_RESP_BYPASS_EN
      checkOutput("bypass_data", 64'(xif.x_data), 64'h5A5A5A5A);
`endif
      step();
      xif.x_p_valid = 1'b0;
      checkOutput("post_push_rvalid", 64'(xif.x_rvalid), 64'd1);
      checkOutput("post_push_err", 64'(err_o), 64'd1);
      xif.x_rready = 1'b1;
      step();
      xif.x_rready = 1'b0;
      checkOutput("final_drained", 64'(xif.x_rvalid), 64'd0);
      checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cv32e40p_x_resp_buffer.md
# cv32e40p_x_resp_buffer

Credit-managed response buffer on the X-interface between the core and the coprocessor wrapper. It passes the request handshake through and sizes it against its own buffer space. Every accepted offload that will write back is guaranteed a FIFO slot, so a coprocessor response is never refused. Responses are queued and replayed to the core in order.

## Interface
- DEPTH, 4: response FIFO entries; legal range 1..16.
- DATA_WIDTH, 32: width of the response data field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- x_valid_i  in  1  core offload request valid.
- x_ready_o  out  1  request ready to core.
- x_accept_o  out  1  accept flag to core (copy of x_k_accept_i).
- x_writeback_o  out  1  writeback flag to core (copy of x_k_writeback_i).
- x_q_valid_o  out  1  request valid to coprocessor.
- x_q_ready_i  in  1  coprocessor request ready.
- x_k_accept_i  in  1  coprocessor accept, valid during the request handshake.
- x_k_writeback_i  in  1  coprocessor will write back, valid during the request handshake.
- x_p_valid_i  in  1  coprocessor response valid.
- x_p_ready_o  out  1  response ready to coprocessor.
- x_p_rd_i, x_p_data_i, x_p_dualwb_i, x_p_type_i, x_p_error_i  in  5/DATA_WIDTH/1/1/1  response payload.
- x_rvalid_o  out  1  response valid to core.
- x_rready_i  in  1  core response ready.
- x_rd_o, x_data_o, x_dualwb_o, x_type_o, x_error_o  out  5/DATA_WIDTH/1/1/1  response payload to core.
- err_o  out  1  sticky protocol error flag.

## Operation
- State:
  - FIFO of DEPTH entries, each {rd, data, dualwb, type, error}.
  - rd_ptr, wr_ptr: wrap at DEPTH, so non-power-of-two DEPTH is legal.
  - count: 0..DEPTH.
  - pending: 0..DEPTH, counting accepted writeback offloads whose response has not yet arrived.
- Credit check: credit_ok = (pending + count) < DEPTH. The sum is computed at $clog2(2*DEPTH+1) bits, so it cannot overflow.
- Request path:
  - x_q_valid_o = x_valid_i & credit_ok.
  - x_ready_o = x_q_ready_i & credit_ok.
  - The request handshake (req_hs) is x_valid_i & x_q_ready_i & credit_ok.
- Reservation: on req_hs with x_k_accept_i & x_k_writeback_i, pending increments. Rejected offloads, and accepted offloads without writeback, consume no credit.
- Push:
  - push = x_p_valid_i & x_p_ready_o, where x_p_ready_o = (count < DEPTH).
  - A push writes the payload at wr_ptr and decrements pending.
- Pop: pop = x_rvalid_o & x_rready_i. A pop advances rd_ptr.
- Simultaneous events:
  - Push and pop in the same cycle leave count unchanged.
  - Reservation and push in the same cycle leave pending unchanged.
  - All four events in one cycle are legal.
- Boundary conditions:
  - FIFO full: x_p_ready_o=0, and a push is refused even if a pop occurs in the same cycle.
  - FIFO empty: x_rvalid_o=0, except in bypass (see Configuration).
  - Push while pending==0 (unsolicited response): the data is still stored if there is space, pending saturates at 0, and err_o is set.
  - Reservation while pending==DEPTH cannot occur, because credit_ok blocks it.
- err_o is cleared only by reset.
- Reset mid-operation clears the FIFO, pointers, count, pending and err_o immediately. Responses in flight are lost.

## Timing
- Reset values:
  - x_rvalid_o=0.
  - Payload outputs all 0.
  - err_o=0.
  - x_p_ready_o=1.
  - x_q_valid_o and x_ready_o follow x_valid_i and x_q_ready_i, since credit_ok=1.
  - x_accept_o and x_writeback_o follow the coprocessor inputs.
- All request-path outputs are combinational from the current inputs and registered state.
- Response latency without bypass: a push in cycle N makes x_rvalid_o=1 in cycle N+1 with the same payload.
- Payload outputs must hold stable while x_rvalid_o=1 and x_rready_i=0.
- Throughput: one push and one pop per cycle.
- Credit released by a pop in cycle N is visible in credit_ok in cycle N+1.

## Configuration
- CV32E40P_X_RESP_BYPASS_EN defined, FIFO empty, push occurring:
  - The push payload drives the core outputs combinationally with x_rvalid_o=1 in the same cycle.
  - If x_rready_i=1, the entry is consumed without being written, and count and pointers are unchanged.
  - pending still decrements.
- CV32E40P_X_RESP_BYPASS_EN undefined: every response passes through the FIFO with 1-cycle latency. There is no combinational path from x_p_* to x_r*.

## Test plan
- Single offload:
  - Stimulus: accept=1, writeback=1 on req_hs; response rd=5, data=32'hDEADBEEF one cycle later.
  - Required: x_rvalid_o rises the next cycle with rd_o=5 and data_o=32'hDEADBEEF; pending returns to 0 and count to 0 after the pop.
- Credit exhaustion:
  - Stimulus: DEPTH=4; four writeback offloads accepted; x_rready_i=0; no responses.
  - Required: the fifth request sees x_ready_o=0 and x_q_valid_o=0. After one response push followed by a pop, x_ready_o returns to 1 the following cycle.
- Order and backpressure:
  - Stimulus: push data 1,2,3,4 with x_rready_i=0, then release x_rready_i.
  - Required: outputs 1,2,3,4 in order; x_p_ready_o=0 while count=4; payload stable throughout the stall.
- Non-writeback offloads:
  - Stimulus: ten offloads with accept=1, writeback=0, followed by one with accept=0.
  - Required: pending stays 0 and x_ready_o stays 1.
- Unsolicited response:
  - Stimulus: a push while pending=0.
  - Required: err_o=1 the next cycle and stays 1; the data is still delivered to the core.
- Reset mid-stream:
  - Stimulus: rst_ni low with count=3, pending=1.
  - Required: x_rvalid_o=0 and err_o=0 immediately; x_p_ready_o=1. With the bypass macro defined, a push into the empty FIFO also shows same-cycle x_rvalid_o.
